// File: rtl/conv_encoder_lrpt.sv
// -----------------------------------------------------------------------------
// conv_encoder_lrpt
//   Rate-1/2, constraint-length-7 convolutional encoder producing signed 8-bit
//   soft symbols in the same format the Viterbi decoder consumes. It is used
//   for loopback benches and FPGA self-test.
//
//   Payload bytes arrive on a valid/ready stream. Each byte is encoded MSB
//   first. Every input bit yields two symbols, c1 then c2. Each symbol is
//   handed off on a valid/ready stream at up to one symbol per cycle. When
//   TAIL_EN is set, six zero tail bits follow the final byte of a frame, so
//   the trellis ends in state 0.
//
// Ports
//   clk      in   1  system clock
//   sys_rst  in   1  asynchronous reset, active-high
//   s_data   in   8  payload byte, MSB encoded first
//   s_valid  in   1  s_data valid
//   s_last   in   1  s_data is the final byte of the frame (qualified by s_valid)
//   s_ready  out  1  byte accepted on s_valid && s_ready
//   m_soft   out  8  signed soft symbol (code 0 -> +SOFT_MAG, 1 -> -SOFT_MAG)
//   m_valid  out  1  m_soft valid
//   m_last   out  1  final symbol of the frame
//   m_ready  in   1  sink accepts the symbol on m_valid && m_ready
// -----------------------------------------------------------------------------
module conv_encoder_lrpt #(
    parameter logic [6:0] G1       = 7'h4F,
    parameter logic [6:0] G2       = 7'h6D,
    parameter int         SOFT_MAG = 127,
    parameter bit         TAIL_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_soft,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready
);

    localparam logic [7:0] SOFT_POS = 8'(SOFT_MAG);
    localparam logic [7:0] SOFT_NEG = 8'd0 - 8'(SOFT_MAG);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    // Even-parity reduction of a 7-bit tap vector.
    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

    // Soft symbol for one input bit, given the register contents it is combined with.
    // sel = 0 selects the G1 output (c1) and sel = 1 selects the G2 output (c2).
    function automatic logic [7:0] soft_sym(input logic in_bit,
                                            input logic [5:0] sr,
                                            input logic sel);
        logic [6:0] w;
        logic       c;
        w = {in_bit, sr};
        if (sel) begin
            c = parity7(w & G2);
        end else begin
            c = parity7(w & G1);
        end
        return c ? SOFT_NEG : SOFT_POS;
    endfunction

    state_t     state_q,   state_d;
    logic [5:0] sr_q,      sr_d;
    logic [7:0] byte_q,    byte_d;
    logic       last_q,    last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sym_sel_q, sym_sel_d;
    logic [7:0] m_soft_q,  m_soft_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q,  m_last_d;

    logic       handoff_s;
    logic       byte_done_s;
    logic       cur_bit_s;
    logic       next_bit_s;
    logic [2:0] bit_cnt_m1_s;
    logic [5:0] sr_adv_s;
    logic       s_ready_s;
    logic       accept_s;

    // Per-cycle helpers: the bit being encoded, the shifted register, and the input handshake.
    always_comb begin
        handoff_s    = m_valid_q & m_ready;
        byte_done_s  = handoff_s & sym_sel_q & (bit_cnt_q == 3'd0);
        bit_cnt_m1_s = bit_cnt_q - 3'd1;
        if (state_q == ST_SHIFT) begin
            cur_bit_s  = byte_q[bit_cnt_q];
            next_bit_s = byte_q[bit_cnt_m1_s];
        end else begin
            // Tail bits are zero.
            cur_bit_s  = 1'b0;
            next_bit_s = 1'b0;
        end
        // The newest bit enters at the top and the oldest bit drops off the bottom.
        sr_adv_s = {cur_bit_s, sr_q[5:1]};
        if (sys_rst) begin
            s_ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            s_ready_s = 1'b1;
        end else if ((state_q == ST_SHIFT) && byte_done_s && !last_q) begin
            // Take the next byte in the same cycle as the 16th symbol, so there is no bubble.
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
        accept_s = s_valid & s_ready_s;
    end

    // Next-state and next-output logic. Every register holds unless a handoff or an accept moves it.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        byte_d    = byte_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        sym_sel_d = sym_sel_q;
        m_soft_d  = m_soft_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SHIFT;
                    byte_d    = s_data;
                    last_d    = s_last;
                    bit_cnt_d = 3'd7;
                    sym_sel_d = 1'b0;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    m_soft_d  = soft_sym(s_data[7], sr_q, 1'b0);
                end else begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    m_soft_d  = 8'd0;
                end
            end

            ST_SHIFT: begin
                if (handoff_s && !sym_sel_q) begin
                    // c1 was taken. Present c2 of the same bit.
                    sym_sel_d = 1'b1;
                    m_soft_d  = soft_sym(cur_bit_s, sr_q, 1'b1);
                    m_last_d  = last_q & (TAIL_EN == 1'b0) & (bit_cnt_q == 3'd0);
                end else if (handoff_s) begin
                    // c2 was taken. The bit is now committed to the shift register.
                    sr_d = sr_adv_s;
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_m1_s;
                        sym_sel_d = 1'b0;
                        m_soft_d  = soft_sym(next_bit_s, sr_adv_s, 1'b0);
                    end else if (!last_q && accept_s) begin
                        byte_d    = s_data;
                        last_d    = s_last;
                        bit_cnt_d = 3'd7;
                        sym_sel_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_soft_d  = soft_sym(s_data[7], sr_adv_s, 1'b0);
                    end else if (last_q && TAIL_EN) begin
                        state_d   = ST_TAIL;
                        bit_cnt_d = 3'd5;
                        sym_sel_d = 1'b0;
                        m_soft_d  = soft_sym(1'b0, sr_adv_s, 1'b0);
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 3'd0;
                        sym_sel_d = 1'b0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_soft_d  = 8'd0;
                    end
                end else begin
                    // The sink is stalling. Hold everything.
                    state_d = ST_SHIFT;
                end
            end

            ST_TAIL: begin
                if (handoff_s && !sym_sel_q) begin
                    sym_sel_d = 1'b1;
                    m_soft_d  = soft_sym(1'b0, sr_q, 1'b1);
                    m_last_d  = (bit_cnt_q == 3'd0);
                end else if (handoff_s) begin
                    sr_d = sr_adv_s;
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_m1_s;
                        sym_sel_d = 1'b0;
                        m_soft_d  = soft_sym(1'b0, sr_adv_s, 1'b0);
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 3'd0;
                        sym_sel_d = 1'b0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_soft_d  = 8'd0;
                    end
                end else begin
                    state_d = ST_TAIL;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                sr_d      = 6'd0;
                bit_cnt_d = 3'd0;
                sym_sel_d = 1'b0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                m_soft_d  = 8'd0;
            end
        endcase
    end

    // State, shift register, and registered output stage.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= 6'd0;
            byte_q    <= 8'd0;
            last_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            sym_sel_q <= 1'b0;
            m_soft_q  <= 8'd0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            sym_sel_q <= sym_sel_d;
            m_soft_q  <= m_soft_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_ready = s_ready_s;
    assign m_soft  = m_soft_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

endmodule
